// File: rtl/mem_ctrl_if.sv
// Fetch, load/store and byte-bus signals shared by the CPU front ends, the memory
// controller and the memory system.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    // Controller side.
    modport slave (
        input  if_req, if_addr, if_flush, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    // Requester and memory side.
    modport master (
        output if_req, if_addr, if_flush, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: arbitrates instruction fetch and load/store onto the
// shared byte bus, freezing while the host owns the bus and replaying any lost bytes.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input logic       clk_in,
    input logic       rst_in,
    input logic       rdy_in,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            st_q, st_d;
    logic              txn_ls_q, txn_ls_d;
    logic              io_q, io_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        iss_q, iss_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic [31:0] merged;
    logic [2:0]  iss_nxt;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        st_d       = st_q;
        txn_ls_d   = txn_ls_q;
        io_d       = io_q;
        n_d        = n_q;
        iss_d      = iss_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        iss_nxt    = iss_q + 3'd1;
        merged     = rbuf_q;
        merged[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;

        case (st_q)
            StIdle: begin
                if (rdy_in && bus.ls_req) begin
                    txn_ls_d = 1'b1;
                    io_d     = (bus.ls_addr[17:16] == IO_HI);
                    n_d      = size_to_n(bus.ls_size);
                    base_d   = bus.ls_addr;
                    wdata_d  = bus.ls_wdata;
                    iss_d    = '0;
                    cnt_d    = '0;
                    pend_d   = 1'b0;
                    rbuf_d   = '0;
                    mem_a_d  = bus.ls_addr;
                    if (bus.ls_we) begin
                        st_d       = StWrite;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = bus.ls_wdata[7:0];
                    end else begin
                        st_d = StRead;
                    end
                end else if (rdy_in && bus.if_req && !bus.if_flush) begin
                    txn_ls_d = 1'b0;
                    io_d     = 1'b0;
                    n_d      = 3'd4;
                    base_d   = bus.if_addr;
                    iss_d    = '0;
                    cnt_d    = '0;
                    pend_d   = 1'b0;
                    rbuf_d   = '0;
                    mem_a_d  = bus.if_addr;
                    st_d     = StRead;
                end
            end
            StRead: begin
                if (!rdy_in) begin
                    // Rewind to the oldest uncaptured byte; IO reads have side effects, so an IO
                    // byte already issued is waited for rather than issued again.
                    if (!io_q) begin
                        iss_d   = cnt_q;
                        pend_d  = 1'b0;
                        mem_a_d = base_q + ADDR_W'(cnt_q);
                    end
                end else begin
                    if (iss_q < n_q) begin
                        pend_d  = 1'b1;
                        iss_d   = iss_nxt;
                        mem_a_d = (iss_nxt < n_q) ? base_q + ADDR_W'(iss_nxt) : '0;
                    end else begin
                        pend_d = 1'b0;
                    end
                    if (pend_q) begin
                        rbuf_d = merged;
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == n_q - 3'd1) begin
                            st_d    = StDone;
                            mem_a_d = '0;
                            if (txn_ls_q) begin
                                ls_rdata_d = merged;
                            end else begin
                                if_data_d = merged;
                            end
                        end
                    end
                end
            end
            StWrite: begin
                if (rdy_in) begin
                    iss_d = iss_nxt;
                    if (iss_nxt == n_q) begin
                        st_d       = StDone;
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                    end else begin
                        mem_a_d    = base_q + ADDR_W'(iss_nxt);
                        mem_dout_d = wdata_q[{iss_nxt[1:0], 3'b000} +: 8];
                    end
                end
            end
            StDone: begin
                if (rdy_in) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase

        // Flush wins even during a host pause so a stale fetch can never complete.
        if (bus.if_flush && !txn_ls_q && (st_q == StRead || st_q == StDone)) begin
            st_d      = StIdle;
            pend_d    = 1'b0;
            mem_a_d   = '0;
            if_data_d = if_data_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            st_q       <= StIdle;
            txn_ls_q   <= 1'b0;
            io_q       <= 1'b0;
            n_q        <= '0;
            iss_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            st_q       <= st_d;
            txn_ls_q   <= txn_ls_d;
            io_q       <= io_d;
            n_q        <= n_d;
            iss_q      <= iss_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.if_done  = (st_q == StDone) && !txn_ls_q && rdy_in;
    assign bus.ls_done  = (st_q == StDone) && txn_ls_q && rdy_in;
    assign bus.if_data  = if_data_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a 128KiB synchronous-read RAM model on the byte bus and
// hand-computed cycle-by-cycle expectations.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] ram [0:131071];
    logic [7:0] din_q;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // While the host owns the bus the RAM sees foreign traffic, so return junk.
    assign bus.mem_din = din_q;
    always @(posedge clk) begin
        if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[16:0]] <= bus.mem_dout;
            din_q <= ram[bus.mem_a[16:0]];
        end else begin
            din_q <= 8'hA5;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_size  = 2'b00;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, bus.mem_dout}, 32'h0);
        chk("rst_if_done", {31'b0, bus.if_done}, 32'h0);
        chk("rst_ls_done", {31'b0, bus.ls_done}, 32'h0);
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
        rst = 1'b0;

        // 1: word fetch
        ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h100; mid();
        chk("t1_idle_a", bus.mem_a, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); mid();
            chk("t1_addr", bus.mem_a, 32'h100 + k);
            chk("t1_no_wr", {31'b0, bus.mem_wr}, 32'h0);
        end
        tick(); mid();
        chk("t1_c5_no_done", {31'b0, bus.if_done}, 32'h0);
        tick(); mid();
        chk("t1_c6_done", {31'b0, bus.if_done}, 32'h1);
        chk("t1_data", bus.if_data, 32'h44332211);
        tick(); bus.if_req = 1'b0; mid();
        chk("t1_done_pulse", {31'b0, bus.if_done}, 32'h0);
        chk("t1_idle_a_after", bus.mem_a, 32'h0);

        // 2: half-word store, unaligned
        tick();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b01;
        bus.ls_addr = 32'h2001; bus.ls_wdata = 32'h0000BEEF;
        mid();
        tick(); mid();
        chk("t2_a0", bus.mem_a, 32'h2001);
        chk("t2_d0", {24'b0, bus.mem_dout}, 32'hEF);
        chk("t2_wr0", {31'b0, bus.mem_wr}, 32'h1);
        tick(); mid();
        chk("t2_a1", bus.mem_a, 32'h2002);
        chk("t2_d1", {24'b0, bus.mem_dout}, 32'hBE);
        chk("t2_wr1", {31'b0, bus.mem_wr}, 32'h1);
        tick(); mid();
        chk("t2_c3_done", {31'b0, bus.ls_done}, 32'h1);
        chk("t2_c3_wr", {31'b0, bus.mem_wr}, 32'h0);
        tick(); bus.ls_req = 1'b0; bus.ls_we = 1'b0; mid();
        chk("t2_ram0", {24'b0, ram[17'h2001]}, 32'hEF);
        chk("t2_ram1", {24'b0, ram[17'h2002]}, 32'hBE);

        // 3: simultaneous requests, load wins
        ram[17'h10] = 8'h5A;
        tick();
        bus.ls_req = 1'b1; bus.ls_size = 2'b00; bus.ls_addr = 32'h10;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        mid();
        tick(); mid();
        chk("t3_ls_a", bus.mem_a, 32'h10);
        tick(); mid();
        tick(); mid();
        chk("t3_c3_ls_done", {31'b0, bus.ls_done}, 32'h1);
        chk("t3_c3_if_done", {31'b0, bus.if_done}, 32'h0);
        chk("t3_rdata", bus.ls_rdata, 32'h0000005A);
        tick(); bus.ls_req = 1'b0; mid();
        chk("t3_c4_idle_a", bus.mem_a, 32'h0);
        tick(); mid();
        chk("t3_c5_if_a", bus.mem_a, 32'h100);
        for (int c = 6; c < 10; c++) begin
            tick(); mid();
            chk("t3_if_wait", {31'b0, bus.if_done}, 32'h0);
        end
        tick(); mid();
        chk("t3_c10_if_done", {31'b0, bus.if_done}, 32'h1);
        chk("t3_if_data", bus.if_data, 32'h44332211);
        tick(); bus.if_req = 1'b0; mid();

        // 4: flush mid-fetch, then a clean fetch
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h100; mid();
        tick(); mid();
        tick(); mid();
        tick(); bus.if_flush = 1'b1; mid();
        tick(); bus.if_flush = 1'b0; bus.if_req = 1'b0; mid();
        chk("t4_c4_idle_a", bus.mem_a, 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick(); mid();
            chk("t4_no_done", {31'b0, bus.if_done}, 32'h0);
        end
        ram[17'h200] = 8'hDE; ram[17'h201] = 8'hAD; ram[17'h202] = 8'hBE; ram[17'h203] = 8'hEF;
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'h200; mid();
        for (int c = 1; c < 6; c++) begin
            tick(); mid();
            chk("t4_refetch_wait", {31'b0, bus.if_done}, 32'h0);
        end
        tick(); mid();
        chk("t4_refetch_done", {31'b0, bus.if_done}, 32'h1);
        chk("t4_refetch_data", bus.if_data, 32'hEFBEADDE);
        tick(); bus.if_req = 1'b0; mid();

        // 5: word load with host pause in cycles 3-5
        ram[17'h300] = 8'hA1; ram[17'h301] = 8'hB2; ram[17'h302] = 8'hC3; ram[17'h303] = 8'hD4;
        tick(); bus.ls_req = 1'b1; bus.ls_size = 2'b10; bus.ls_addr = 32'h300; mid();
        tick(); mid();
        tick(); mid();
        tick(); rdy = 1'b0; mid();
        chk("t5_c3_no_done", {31'b0, bus.ls_done}, 32'h0);
        tick(); mid();
        chk("t5_c4_rewind_a", bus.mem_a, 32'h301);
        tick(); mid();
        chk("t5_c5_no_done", {31'b0, bus.ls_done}, 32'h0);
        tick(); rdy = 1'b1; mid();
        chk("t5_c6_reissue_a", bus.mem_a, 32'h301);
        chk("t5_c6_no_done", {31'b0, bus.ls_done}, 32'h0);
        for (int c = 7; c < 10; c++) begin
            tick(); mid();
            chk("t5_wait", {31'b0, bus.ls_done}, 32'h0);
        end
        tick(); mid();
        chk("t5_c10_done", {31'b0, bus.ls_done}, 32'h1);
        chk("t5_rdata", bus.ls_rdata, 32'hD4C3B2A1);
        tick(); bus.ls_req = 1'b0; mid();

        // 6: async reset mid word store
        tick();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10;
        bus.ls_addr = 32'h400; bus.ls_wdata = 32'h11223344;
        mid();
        tick(); mid();
        chk("t6_wr0", {31'b0, bus.mem_wr}, 32'h1);
        chk("t6_d0", {24'b0, bus.mem_dout}, 32'h44);
        tick(); mid();
        chk("t6_a1", bus.mem_a, 32'h401);
        rst = 1'b1;
        #1;
        chk("t6_rst_wr", {31'b0, bus.mem_wr}, 32'h0);
        chk("t6_rst_a", bus.mem_a, 32'h0);
        chk("t6_rst_dout", {24'b0, bus.mem_dout}, 32'h0);
        chk("t6_rst_done", {31'b0, bus.ls_done}, 32'h0);
        bus.ls_req = 1'b0; bus.ls_we = 1'b0;
        tick(); mid(); rst = 1'b0;
        tick(); mid();
        chk("t6_no_done", {31'b0, bus.ls_done}, 32'h0);
        chk("t6_ram400", {24'b0, ram[17'h400]}, 32'h44);
        chk("t6_ram401", {24'b0, ram[17'h401]}, 32'h00);
        tick(); bus.ls_req = 1'b1; bus.ls_size = 2'b10; bus.ls_addr = 32'h400; mid();
        for (int c = 1; c < 6; c++) begin
            tick(); mid();
            chk("t6_load_wait", {31'b0, bus.ls_done}, 32'h0);
        end
        tick(); mid();
        chk("t6_load_done", {31'b0, bus.ls_done}, 32'h1);
        chk("t6_load_data", bus.ls_rdata, 32'h00000044);
        tick(); bus.ls_req = 1'b0; mid();

        // 7: fetch wrapping past 2^32, pause held over the done cycle
        ram[17'h1FFFE] = 8'h12; ram[17'h1FFFF] = 8'h34; ram[17'h0] = 8'h56; ram[17'h1] = 8'h78;
        tick(); bus.if_req = 1'b1; bus.if_addr = 32'hFFFF_FFFE; mid();
        tick(); mid();
        chk("t7_a0", bus.mem_a, 32'hFFFF_FFFE);
        tick(); mid();
        chk("t7_a1", bus.mem_a, 32'hFFFF_FFFF);
        tick(); mid();
        chk("t7_a2_wrap", bus.mem_a, 32'h0000_0000);
        tick(); mid();
        chk("t7_a3", bus.mem_a, 32'h0000_0001);
        tick(); mid();
        tick(); rdy = 1'b0; mid();
        chk("t7_paused_no_done", {31'b0, bus.if_done}, 32'h0);
        tick(); rdy = 1'b1; mid();
        chk("t7_done", {31'b0, bus.if_done}, 32'h1);
        chk("t7_data", bus.if_data, 32'h78563412);
        tick(); bus.if_req = 1'b0; mid();
        chk("t7_done_pulse", {31'b0, bus.if_done}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
